// File: rtl/fetch_pkg.sv
// Shared defaults and the fetch queue entry type for the instruction fetch stage.
package fetch_pkg;
  localparam int XLEN_DEF    = 32;
  localparam int ILEN_DEF    = 32;
  localparam int PC_STEP_DEF = 1;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries; flush empties it and overrides push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_entry,
  input  logic          pop,
  output entry_t        head_entry,
  output logic          head_valid,
  output logic [CW-1:0] count
);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk1) begin
    mem_q <= mem_d;
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;
endmodule

// File: rtl/fetch_stage_q.sv
// Instruction fetch stage: PC register, combinational imem read, fetch queue toward decode.
// Handshake: an entry transfers on a rising edge where out_valid && out_ready; out_valid and the head hold until then.
module fetch_stage_q
  import fetch_pkg::*;
#(
  parameter int  XLEN     = XLEN_DEF,
  parameter int  ILEN     = ILEN_DEF,
  parameter int  FQ_DEPTH = 4,
  parameter int  PC_STEP  = PC_STEP_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  localparam int CW       = $clog2(FQ_DEPTH) + 1
) (
  input  logic            clk1,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_en,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [CW-1:0]   fq_count
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } stage_entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pop, push_ok;
  stage_entry_t    push_entry, head_entry;
  logic [CW-1:0]   count;

  // A full queue still accepts a fetch when the head leaves in the same cycle.
  always_comb begin
    pop        = out_valid && out_ready;
    push_ok    = !rst && !redirect_valid && ((count < CW'(FQ_DEPTH)) || pop);
    push_entry = '{pc: pc_q, instr: imem_rdata};
    pc_d       = pc_q;
    if (redirect_valid)  pc_d = redirect_pc;
    else if (push_ok)    pc_d = pc_q + XLEN'(PC_STEP);
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  fetch_queue #(
    .entry_t (stage_entry_t),
    .DEPTH   (FQ_DEPTH)
  ) u_fetch_queue (
    .clk1       (clk1),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push_ok),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .head_valid (out_valid),
    .count      (count)
  );

  assign imem_addr = pc_q;
  assign imem_en   = push_ok;
  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;
  assign fq_count  = count;
endmodule
